// File: rtl/tap_data_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tap_data_regs
//  Description : JTAG instruction register plus BYPASS/IDCODE/USER data
//                registers, driven by the TAP controller's state observation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_data_regs #(
    parameter int          IR_W     = 3,
    parameter int          USER_W   = 8,
    parameter logic [31:0] IDCODE   = 32'h1000_0A5B,
    parameter logic [USER_W-1:0] USER_RST = '0
) (
    input  logic              GCLK_Pad,
    input  logic              RSTN_Pad,
    input  logic [2:0]        St_obs,
    input  logic              TDI_Pad,
    input  logic [USER_W-1:0] user_in,
    output logic              TDO_Pad,
    output logic [IR_W-1:0]   ir_out,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd
);

    localparam logic [2:0] c_ST_TLR    = 3'd0;
    localparam logic [2:0] c_ST_RTI    = 3'd1;
    localparam logic [2:0] c_ST_CAP_DR = 3'd2;
    localparam logic [2:0] c_ST_SH_DR  = 3'd3;
    localparam logic [2:0] c_ST_UPD_DR = 3'd4;
    localparam logic [2:0] c_ST_CAP_IR = 3'd5;
    localparam logic [2:0] c_ST_SH_IR  = 3'd6;
    localparam logic [2:0] c_ST_UPD_IR = 3'd7;

    // Every code other than IDCODE and USER decodes to BYPASS.
    localparam logic [IR_W-1:0] c_INS_IDCODE  = IR_W'(1);
    localparam logic [IR_W-1:0] c_INS_USER    = IR_W'(2);
    localparam logic [IR_W-1:0] c_IR_CAPTURE  = IR_W'(1);

    logic [IR_W-1:0]   r_ir_sr;
    logic [IR_W-1:0]   r_ir_out;
    logic              r_bp;
    logic [31:0]       r_id_sr;
    logic [USER_W-1:0] r_us_sr;
    logic [USER_W-1:0] r_user_out;
    logic              r_user_upd;
    logic              r_tdo;

    logic [IR_W-1:0]   w_ir_shift;
    logic [31:0]       w_id_shift;
    logic [USER_W-1:0] w_us_shift;
    logic              w_sel_id;
    logic              w_sel_user;
    logic              w_tdo_nxt;

    assign w_ir_shift = {TDI_Pad, r_ir_sr[IR_W-1:1]};
    assign w_id_shift = {TDI_Pad, r_id_sr[31:1]};

    generate
        if (USER_W == 1) begin : g_us_shift_1
            assign w_us_shift = TDI_Pad;
        end else begin : g_us_shift_n
            assign w_us_shift = {TDI_Pad, r_us_sr[USER_W-1:1]};
        end
    endgenerate

    assign w_sel_id   = (r_ir_out == c_INS_IDCODE);
    assign w_sel_user = (r_ir_out == c_INS_USER);

    // TDO carries bit0 of whatever register the current state just loaded or shifted.
    always_comb begin
        w_tdo_nxt = 1'b0;
        case (St_obs)
            c_ST_CAP_IR: w_tdo_nxt = c_IR_CAPTURE[0];
            c_ST_SH_IR:  w_tdo_nxt = w_ir_shift[0];
            c_ST_CAP_DR: begin
                if (w_sel_id)
                    w_tdo_nxt = IDCODE[0];
                else if (w_sel_user)
                    w_tdo_nxt = user_in[0];
                else
                    w_tdo_nxt = 1'b0;
            end
            c_ST_SH_DR: begin
                if (w_sel_id)
                    w_tdo_nxt = w_id_shift[0];
                else if (w_sel_user)
                    w_tdo_nxt = w_us_shift[0];
                else
                    w_tdo_nxt = TDI_Pad;
            end
            default: w_tdo_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
        if (!RSTN_Pad) begin
            r_ir_sr    <= '0;
            r_ir_out   <= c_INS_IDCODE;
            r_bp       <= 1'b0;
            r_id_sr    <= '0;
            r_us_sr    <= '0;
            r_user_out <= USER_RST;
            r_user_upd <= 1'b0;
            r_tdo      <= 1'b0;
        end else begin
            r_user_upd <= 1'b0;
            r_tdo      <= w_tdo_nxt;
            case (St_obs)
                c_ST_TLR:    r_ir_out <= c_INS_IDCODE;
                c_ST_RTI:    ;
                c_ST_CAP_IR: r_ir_sr  <= c_IR_CAPTURE;
                c_ST_SH_IR:  r_ir_sr  <= w_ir_shift;
                c_ST_UPD_IR: r_ir_out <= r_ir_sr;
                c_ST_CAP_DR: begin
                    if (w_sel_id)
                        r_id_sr <= IDCODE;
                    else if (w_sel_user)
                        r_us_sr <= user_in;
                    else
                        r_bp <= 1'b0;
                end
                c_ST_SH_DR: begin
                    if (w_sel_id)
                        r_id_sr <= w_id_shift;
                    else if (w_sel_user)
                        r_us_sr <= w_us_shift;
                    else
                        r_bp <= TDI_Pad;
                end
                c_ST_UPD_DR: begin
                    if (w_sel_user) begin
                        r_user_out <= r_us_sr;
                        r_user_upd <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign TDO_Pad  = r_tdo;
    assign ir_out   = r_ir_out;
    assign user_out = r_user_out;
    assign user_upd = r_user_upd;

endmodule
`default_nettype wire
